fetch_prefetch_buf: RTL

Instruction fetch stage directly upstream of the processor core's decode logic. Owns the program counter and issues word fetches to instruction memory over a request/grant/response interface. Buffers returned instructions with their PCs in a small in-order prefetch FIFO and hands them to decode over a valid/ready handshake. Branch/jump redirects from the core flush the buffer and discard stale in-flight responses.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_prefetch_buf_sync_fifo.sv | 57 +++++
 rtl/fetch_prefetch_buf.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch / prefetch buffer slice.
package fetch_pkg;

  localparam int unsigned DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam int unsigned PC_INCR          = 4;

endpackage

// File: rtl/fetch_prefetch_buf_sync_fifo.sv
// Small in-order FIFO with synchronous flush; head word is read straight from storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_prefetch_buf.sv
// Fetch stage: owns the PC, issues credit-limited fetches, buffers {instr, pc} for decode.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_prefetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = DEFAULT_XLEN,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

  logic              grant, resp_keep, fifo_push, fifo_pop;
  logic              fifo_empty, fifo_full, pcq_empty, pcq_full;
  logic [CW-1:0]     fifo_count, pcq_count;
  logic [CW:0]       inflight_total;
  logic [XLEN-1:0]   pcq_head;
  logic [2*XLEN-1:0] fifo_head;
  logic              unused_sigs;

  // Credit covers both buffered entries and responses still on their way.
  assign inflight_total = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req  = !reset && !redirect_valid && (inflight_total < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  assign resp_keep = imem_rvalid && (drop_cnt_q == '0) && !redirect_valid;
  assign fifo_push = resp_keep;
  assign fifo_pop  = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];
  assign instr_pc    = fifo_empty ? '0 : fifo_head[XLEN-1:0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    if (grant) fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // Only responses that have not yet arrived are stale from here on.
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
    end else if (imem_rvalid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (grant),
    .wdata_i (fetch_pc_q),
    .pop_i   (resp_keep),
    .rdata_o (pcq_head),
    .empty_o (pcq_empty),
    .full_o  (pcq_full),
    .count_o (pcq_count)
  );

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .wdata_i ({imem_rdata, pcq_head}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign unused_sigs = ^{pcq_empty, pcq_full, pcq_count, fifo_full, redirect_pc[1:0]};

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (fifo_pop)                   perf_fetched_q <= perf_fetched_q + 32'd1;
      if (instr_ready && !instr_valid) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
